count_capture_fifo: RTL and testbench
=====================================

Name: count_capture_fifo

Overview:
- Downstream consumer of the 4-bit binary counter output (Q).
- On each `capture` strobe it snapshots the live count into a small first-word-fall-through FIFO.
- A consumer drains the FIFO through a valid/ready handshake.
- Lets a slower reader (monitor, UART formatter) log counter values without missing samples, up to DEPTH outstanding entries.

Parameters:
- DATA_W, 4, width of the sampled count and of each FIFO entry.
- DEPTH, 4, number of entries; must be a power of 2, at least 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- reset  input  1  synchronous, active-low reset; 0 at a rising clk edge resets the block.
- din  input  DATA_W  live counter value; connects directly to counter Q.
- capture  input  1  push request; sampled at the rising clk edge.
- dout  output  DATA_W  oldest stored entry; 0 when empty.
- dout_valid  output  1  high while the FIFO holds at least one entry.
- dout_ready  input  1  consumer accepts dout this cycle.
- level  output  AW+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- overflow  output  1  a capture was dropped; timing set by Optional Feature.

Behaviour:
- All state is updated only on the rising clk edge. There are no asynchronous paths.
- Reset (reset==0 at an edge):
  - wr_ptr=0, rd_ptr=0, level=0, overflow=0.
  - Outputs: empty=1, full=0, dout_valid=0, dout=0.
  - Memory contents are don't-care.
  - Reset takes priority over capture and pop in the same cycle.
  - Reset mid-operation discards all stored entries.
- Push condition: capture==1 && (!full || pop). On push, mem[wr_ptr] <= din and wr_ptr increments modulo DEPTH (natural AW-bit wrap).
- Pop condition: dout_valid && dout_ready. On pop, rd_ptr increments modulo DEPTH.
- dout_ready while empty is ignored; no state change.
- level update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push+pop.
  - Never exceeds DEPTH and never goes below 0.
- Output timing:
  - dout is combinational from mem[rd_ptr], gated to 0 when empty.
  - dout_valid = !empty.
  - full and empty decode combinationally from the level register.
- Latency: data pushed at edge N is visible on dout, with dout_valid=1, in the cycle after edge N if the FIFO was empty.
  - No empty-bypass: a capture and a ready in the same cycle while empty produce only a push.
- Full + capture + pop in the same cycle: both occur, the new value is accepted, level stays DEPTH, overflow is not raised.
- Full + capture without pop: din is dropped, pointers and level are unchanged, and the overflow event is raised.
- capture held high: a push occurs on every edge. This samples consecutive counter values, e.g. 3,4,5,6.
- Order is strict FIFO across pointer wrap-around.

Optional Feature:
- Macro: COUNT_CAPTURE_FIFO_OVF_STICKY_EN.
- Undefined: overflow is a one-cycle pulse, high in the cycle after each dropped capture. Back-to-back drops give consecutive high cycles.
- Defined: overflow sets on the first dropped capture and stays high until reset. Pops and further pushes do not clear it.

Test Plan:
1. Reset, then din counts 0..F each cycle, capture pulsed when din=3, 7, B. Required:
   - dout_valid rises the cycle after the first capture.
   - With dout_ready=1, dout reads 3, 7, B in order.
   - level returns to 0, empty=1, dout=0.
2. Fill and overflow: dout_ready=0, capture held 5 cycles with din=1..5. Required:
   - level reads 1, 2, 3, 4, 4; full=1 after the 4th push.
   - The 5th capture is dropped and overflow goes high the next cycle (pulse build: 1 cycle; sticky build: stays 1).
   - Draining yields 1, 2, 3, 4.
3. Full with simultaneous capture+pop: FIFO holds 1, 2, 3, 4, then din=9 with capture=1 and dout_ready=1. Required:
   - level stays 4 and overflow stays 0.
   - Subsequent reads give 2, 3, 4, 9.
4. Wrap-around: 10 push/pop pairs interleaved, with level kept at 1..3, through din values 0..9. Required: output order equals input order and there is no spurious full/empty.
5. Reset mid-operation: FIFO holds 3 entries and overflow is set (sticky build), then reset=0 for one edge. Required:
   - Next cycle level=0, empty=1, dout_valid=0, dout=0, overflow=0.
   - A capture asserted during the reset cycle is ignored.
6. Ready while empty: level=0 with dout_ready=1 and no capture for 3 cycles. Required: level stays 0, no pointer movement, and a later single capture of din=E is read as E.

Source files
------------

// File: rtl/count_capture_fifo.sv
// count_capture_fifo: snapshots a live counter value into a small
// first-word-fall-through FIFO on each capture strobe. A consumer drains the
// FIFO through a valid/ready handshake.
// Optional build macro COUNT_CAPTURE_FIFO_OVF_STICKY_EN makes overflow
// sticky until reset; otherwise it is a one-cycle pulse per dropped capture.
module count_capture_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              capture,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [AW:0]       level,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              push, pop, drop;

  assign empty      = (level_q == '0);
  assign full       = (level_q == LVL_FULL);
  assign dout_valid = !empty;
  assign dout       = empty ? '0 : mem_q[rd_ptr_q];
  assign level      = level_q;
  assign overflow   = ovf_q;

  // A pop in the same cycle frees a slot, so a full FIFO may still accept.
  assign pop  = dout_valid && dout_ready;
  assign push = capture && (!full || pop);
  assign drop = capture && full && !pop;

  // Next-state for pointers, occupancy and the overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
`ifdef COUNT_CAPTURE_FIFO_OVF_STICKY_EN
    ovf_d = ovf_q || drop;
`else
    ovf_d = drop;
`endif
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents need no reset since dout is gated when empty.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed self-checking bench for count_capture_fifo.
module tb_count_capture_fifo;

`ifdef COUNT_CAPTURE_FIFO_OVF_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic       capture;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [2:0] level;
  logic       full;
  logic       empty;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  count_capture_fifo #(.DATA_W(4), .DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .capture    (capture),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; capture = 1'b0; dout_ready = 1'b0; din = '0;
    step;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL rst_level act=%0d exp=0", level); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty act=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full act=%b exp=0", full); end
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL rst_valid act=%b exp=0", dout_valid); end
    checks++; if (dout !== 4'h0) begin failures++; $display("FAIL rst_dout act=%h exp=0", dout); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf act=%b exp=0", overflow); end
  endtask

  // Counter sweep 0..F, captures at 3, 7, B, consumer always ready.
  task automatic test_capture_sweep;
    logic cap;
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 4'(i);
      cap = (i == 3) || (i == 7) || (i == 11);
      capture = cap;
      step;
      checks++; if (dout_valid !== cap) begin failures++; $display("FAIL sweep_valid i=%0d act=%b exp=%b", i, dout_valid, cap); end
      checks++; if (dout !== (cap ? 4'(i) : 4'h0)) begin failures++; $display("FAIL sweep_dout i=%0d act=%h exp=%h", i, dout, cap ? 4'(i) : 4'h0); end
      checks++; if (level !== (cap ? 3'd1 : 3'd0)) begin failures++; $display("FAIL sweep_level i=%0d act=%0d exp=%0d", i, level, cap ? 1 : 0); end
    end
    capture = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL sweep_empty act=%b exp=1", empty); end
    checks++; if (dout !== 4'h0) begin failures++; $display("FAIL sweep_dout_end act=%h exp=0", dout); end
  endtask

  task automatic test_fill_overflow;
    do_reset;
    dout_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      din = 4'(i); capture = 1'b1;
      step;
      checks++; if (level !== 3'((i < 5) ? i : 4)) begin failures++; $display("FAIL fill_level i=%0d act=%0d exp=%0d", i, level, (i < 5) ? i : 4); end
      checks++; if (full !== (i >= 4)) begin failures++; $display("FAIL fill_full i=%0d act=%b exp=%b", i, full, i >= 4); end
      checks++; if (overflow !== (i == 5)) begin failures++; $display("FAIL fill_ovf i=%0d act=%b exp=%b", i, overflow, i == 5); end
    end
    capture = 1'b0;
    step;
    checks++; if (overflow !== STICKY) begin failures++; $display("FAIL ovf_after act=%b exp=%b", overflow, STICKY); end
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL ovf_level act=%0d exp=4", level); end
    dout_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (dout !== 4'(i)) begin failures++; $display("FAIL drain_dout i=%0d act=%h exp=%h", i, dout, 4'(i)); end
      step;
    end
    dout_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty act=%b exp=1", empty); end
  endtask

  task automatic test_full_push_pop;
    do_reset;
    dout_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      din = 4'(i); capture = 1'b1;
      step;
    end
    din = 4'h9; capture = 1'b1; dout_ready = 1'b1;
    step;
    capture = 1'b0;
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL fpp_level act=%0d exp=4", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fpp_ovf act=%b exp=0", overflow); end
    for (int k = 0; k < 4; k++) begin
      logic [3:0] e;
      e = (k < 3) ? 4'(k + 2) : 4'h9;
      checks++; if (dout !== e) begin failures++; $display("FAIL fpp_dout k=%0d act=%h exp=%h", k, dout, e); end
      step;
    end
    dout_ready = 1'b0;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL fpp_level_end act=%0d exp=0", level); end
  endtask

  // Preload 0,1 then push i while popping i-2; pointers wrap twice.
  task automatic test_wrap;
    do_reset;
    dout_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din = 4'(i); capture = 1'b1;
      step;
    end
    dout_ready = 1'b1;
    for (int i = 2; i < 10; i++) begin
      din = 4'(i); capture = 1'b1;
      checks++; if (dout !== 4'(i - 2)) begin failures++; $display("FAIL wrap_dout i=%0d act=%h exp=%h", i, dout, 4'(i - 2)); end
      step;
      checks++; if (level !== 3'd2 || full !== 1'b0 || empty !== 1'b0) begin failures++; $display("FAIL wrap_flags i=%0d act=%0d/%b/%b exp=2/0/0", i, level, full, empty); end
    end
    capture = 1'b0;
    for (int i = 8; i < 10; i++) begin
      checks++; if (dout !== 4'(i)) begin failures++; $display("FAIL wrap_tail i=%0d act=%h exp=%h", i, dout, 4'(i)); end
      step;
    end
    dout_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty act=%b exp=1", empty); end
  endtask

  task automatic test_mid_reset;
    do_reset;
    dout_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      din = 4'(i); capture = 1'b1;
      step;
    end
    capture = 1'b0; dout_ready = 1'b1;
    step;
    dout_ready = 1'b0;
    checks++; if (level !== 3'd3) begin failures++; $display("FAIL mr_pre_level act=%0d exp=3", level); end
    checks++; if (overflow !== STICKY) begin failures++; $display("FAIL mr_pre_ovf act=%b exp=%b", overflow, STICKY); end
    reset = 1'b0; capture = 1'b1; din = 4'h7;
    step;
    reset = 1'b1; capture = 1'b0;
    checks++; if (level !== 3'd0 || empty !== 1'b1 || dout_valid !== 1'b0) begin failures++; $display("FAIL mr_state act=%0d/%b/%b exp=0/1/0", level, empty, dout_valid); end
    checks++; if (dout !== 4'h0) begin failures++; $display("FAIL mr_dout act=%h exp=0", dout); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mr_ovf act=%b exp=0", overflow); end
    step;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL mr_ignored act=%0d exp=0", level); end
  endtask

  task automatic test_ready_empty;
    dout_ready = 1'b1; capture = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      checks++; if (level !== 3'd0) begin failures++; $display("FAIL re_level k=%0d act=%0d exp=0", k, level); end
    end
    din = 4'hE; capture = 1'b1;
    step;
    capture = 1'b0;
    checks++; if (dout_valid !== 1'b1 || dout !== 4'hE) begin failures++; $display("FAIL re_dout act=%b/%h exp=1/e", dout_valid, dout); end
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL re_level1 act=%0d exp=1", level); end
    step;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL re_empty act=%b exp=1", empty); end
  endtask

  initial begin
    reset = 1'b0; capture = 1'b0; dout_ready = 1'b0; din = '0;
    test_reset;
    test_capture_sweep;
    test_fill_overflow;
    test_full_push_pop;
    test_wrap;
    test_mid_reset;
    test_ready_empty;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
